memctrl: RTL and testbench

Memory controller that serves the load/store buffer's single outstanding request over the byte-wide, one-cycle-latency RAM/IO bus. It accepts a level-held request (`ls_enable`, `addr`, `store_val`, `lsb_type`) and splits it into 1, 2 or 4 little-endian byte transfers. It then returns a one-cycle `ls_finished` pulse, with `load_val` sign- or zero-extended for loads. It sits between the LSB and the top-level RAM port.

---
 rtl/memctrl_pkg.sv | 37 +++
 rtl/memctrl_ls_extend.sv | 28 ++
 rtl/memctrl.sv | 154 +++++++++++++++
 tb/tb_memctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/memctrl_pkg.sv
// Shared definitions for the memory controller and the load/store buffer:
// lsb_type request codes, field positions inside lsb_type, FSM state encoding.
package memctrl_pkg;

    // Request codes, shared with the LSB
    localparam logic [3:0] LS_LB  = 4'b0000;
    localparam logic [3:0] LS_LH  = 4'b0001;
    localparam logic [3:0] LS_LW  = 4'b0010;
    localparam logic [3:0] LS_LBU = 4'b0100;
    localparam logic [3:0] LS_LHU = 4'b0101;
    localparam logic [3:0] LS_SB  = 4'b1000;
    localparam logic [3:0] LS_SH  = 4'b1001;
    localparam logic [3:0] LS_SW  = 4'b1010;

    // Field positions inside lsb_type
    localparam int TYPE_SIZE_LSB     = 0;
    localparam int TYPE_SIZE_MSB     = 1;
    localparam int TYPE_UNSIGNED_BIT = 2;
    localparam int TYPE_STORE_BIT    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of bytes moved by a request: 1, 2 or 4
    function automatic logic [2:0] ls_bytes(input logic [3:0] t);
        case (t[TYPE_SIZE_MSB:TYPE_SIZE_LSB])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/memctrl_ls_extend.sv
// ls_extend: sign/zero extension of an assembled little-endian load word.
// Byte and halfword loads extend from bit 7/15; the unsigned bit selects
// zero extension. Words pass through unchanged.
module ls_extend
    import memctrl_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [3:0]  lsb_type,
    output logic [31:0] val
);

    logic sext;
    logic unused_store_bit;

    assign sext             = ~lsb_type[TYPE_UNSIGNED_BIT];
    assign unused_store_bit = lsb_type[TYPE_STORE_BIT];

    // Pick the extension width from the size field
    always_comb begin
        val = raw;
        case (lsb_type[TYPE_SIZE_MSB:TYPE_SIZE_LSB])
            2'b00:   val = {{24{sext & raw[7]}},  raw[7:0]};
            2'b01:   val = {{16{sext & raw[15]}}, raw[15:0]};
            default: val = raw;
        endcase
    end

endmodule

// File: rtl/memctrl.sv
// memctrl: serves one level-held LSB request over the byte-wide RAM/IO bus,
// splitting it into 1/2/4 little-endian byte transfers and returning a
// one-cycle ls_finished pulse with the extended load value.
// Optional build macro: MEMCTRL_IO_STALL_EN (hold IO-space store bytes while
// the UART TX buffer is full).
module memctrl
    import memctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic              ls_enable,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_val,
    input  logic [3:0]        lsb_type,
    output logic              ls_finished,
    output logic [31:0]       load_val,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_t            state;
    logic [2:0]        cnt;        // LOAD: bytes issued so far; STORE: current byte
    logic [2:0]        n_bytes;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] a_q;        // address of the byte currently on the bus
    logic [ADDR_W-1:0] pend_a;     // address whose data is due on mem_din
    logic [31:0]       sval_q;
    logic [31:0]       data_q;
    logic [31:0]       data_next;
    logic [31:0]       ext_val;
    logic [3:0]        type_q;
    logic [7:0]        dout_q;
    logic              wr_q;
    logic              squash_q;   // store was flushed: finish it but stay silent
    logic              io_stall;
    logic [1:0]        cap_lane;
    logic [1:0]        nxt_lane;

    assign n_bytes  = ls_bytes(type_q);
    assign cap_lane = cnt[1:0] - 2'd1;
    assign nxt_lane = cnt[1:0] + 2'd1;
    assign pend_a   = base_q + ADDR_W'(cnt) - ADDR_W'(1);

`ifdef MEMCTRL_IO_STALL_EN
    assign io_stall = (a_q[17:16] == 2'b11) && io_buffer_full;
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign io_stall       = 1'b0;
`endif

    // While paused mid-load the RAM keeps sampling mem_a, so re-present the
    // address whose byte is still owed; on resume mem_din then holds it again.
    assign mem_a    = (state == ST_LOAD && !rdy_in && cnt != 3'd0) ? pend_a : a_q;
    assign mem_wr   = wr_q & rdy_in & ~io_stall;
    assign mem_dout = dout_q;

    // Merge the byte arriving this cycle into its lane of the load word
    always_comb begin
        data_next = data_q;
        data_next[{cap_lane, 3'b000} +: 8] = mem_din;
    end

    ls_extend u_ext (
        .raw      (data_next),
        .lsb_type (type_q),
        .val      (ext_val)
    );

    // Request FSM, byte counter, address stepping and data assembly
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= ST_IDLE;
            cnt         <= 3'd0;
            base_q      <= '0;
            a_q         <= '0;
            sval_q      <= '0;
            data_q      <= '0;
            type_q      <= '0;
            dout_q      <= '0;
            wr_q        <= 1'b0;
            squash_q    <= 1'b0;
            ls_finished <= 1'b0;
            load_val    <= '0;
        end else if (rdy_in) begin
            case (state)
                ST_IDLE: begin
                    if (ls_enable) begin
                        base_q   <= addr;
                        a_q      <= addr;
                        sval_q   <= store_val;
                        type_q   <= lsb_type;
                        cnt      <= 3'd0;
                        data_q   <= '0;
                        squash_q <= 1'b0;
                        if (lsb_type[TYPE_STORE_BIT]) begin
                            state  <= ST_STORE;
                            wr_q   <= 1'b1;
                            dout_q <= store_val[7:0];
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (clear) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt != 3'd0)
                            data_q <= data_next;
                        // hold on the last byte rather than touch base+N
                        if (cnt + 3'd1 < n_bytes)
                            a_q <= a_q + ADDR_W'(1);
                        if (cnt == n_bytes) begin
                            state       <= ST_DONE;
                            ls_finished <= 1'b1;
                            load_val    <= ext_val;
                        end
                    end
                end
                ST_STORE: begin
                    squash_q <= squash_q | clear;
                    if (!io_stall) begin
                        if (cnt + 3'd1 == n_bytes) begin
                            wr_q        <= 1'b0;
                            state       <= ST_DONE;
                            ls_finished <= ~(squash_q | clear);
                        end else begin
                            cnt    <= cnt + 3'd1;
                            a_q    <= a_q + ADDR_W'(1);
                            dout_q <= sval_q[{nxt_lane, 3'b000} +: 8];
                        end
                    end
                end
                ST_DONE: begin
                    ls_finished <= 1'b0;
                    load_val    <= '0;
                    squash_q    <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memctrl.sv
// Directed bench for memctrl: a byte RAM model with one-cycle read latency,
// per-request trace capture, hand-computed expectations.
// Build with MEMCTRL_IO_STALL_EN defined to exercise the IO stall timing.
module tb_memctrl;
    import memctrl_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, ls_enable, io_buffer_full;
    logic [31:0] addr, store_val, load_val, mem_a;
    logic [3:0]  lsb_type;
    logic        ls_finished, mem_wr;
    logic [7:0]  mem_din, mem_dout;

    int n_chk = 0;
    int n_fail = 0;

    // per-request trace
    int          fin_cnt, fin_rel, wr_cnt;
    logic [31:0] fin_val;
    logic [31:0] wr_a [8];
    logic [7:0]  wr_d [8];
    int          wr_rel [8];
    logic [31:0] a_tr [32];

    logic [7:0] ram [logic [31:0]];

    memctrl #(.ADDR_W(32)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clear          (clear),
        .ls_enable      (ls_enable),
        .addr           (addr),
        .store_val      (store_val),
        .lsb_type       (lsb_type),
        .ls_finished    (ls_finished),
        .load_val       (load_val),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // RAM: read data for the address seen at this edge appears next cycle
    always @(posedge clk_in) begin
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at #1 after a rising edge (cycle T). Trace covers T+1..T+ncyc.
    task automatic run(input logic [3:0] t, input logic [31:0] a, input logic [31:0] v,
                       input int clr_at, input int rdy_lo, input int rdy_len,
                       input int io_len, input int ncyc);
        fin_cnt = 0; fin_rel = -1; fin_val = 0; wr_cnt = 0;
        ls_enable = 1'b1; addr = a; store_val = v; lsb_type = t;
        io_buffer_full = (io_len > 0);
        for (int r = 1; r <= ncyc; r++) begin
            @(posedge clk_in); #1;
            if (fin_cnt > 0) ls_enable = 1'b0;
            if (clr_at >= 0 && r >= clr_at) ls_enable = 1'b0;
            clear          = (r == clr_at);
            rdy_in         = !(r >= rdy_lo && r < rdy_lo + rdy_len);
            io_buffer_full = (r <= io_len);
            @(negedge clk_in);
            if (r < 32) a_tr[r] = mem_a;
            if (mem_wr && wr_cnt < 8) begin
                wr_a[wr_cnt] = mem_a; wr_d[wr_cnt] = mem_dout; wr_rel[wr_cnt] = r;
                wr_cnt++;
            end
            if (ls_finished) begin
                fin_cnt++;
                if (fin_rel < 0) begin fin_rel = r; fin_val = load_val; end
            end
        end
        @(posedge clk_in); #1;
        ls_enable = 1'b0; clear = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
    endtask

    initial begin
        int idle_wr, idle_fin;
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; ls_enable = 1'b0;
        io_buffer_full = 1'b0; addr = '0; store_val = '0; lsb_type = '0;
        ram[32'h1000] = 8'h78; ram[32'h1001] = 8'h56;
        ram[32'h1002] = 8'h34; ram[32'h1003] = 8'h12;
        ram[32'h0020] = 8'h80;
        ram[32'h0040] = 8'hF0; ram[32'h0041] = 8'h8F;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_finished", {31'd0, ls_finished}, 32'd0);
        chk("rst_load_val", load_val, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // LW at 0x1000
        run(LS_LW, 32'h1000, 0, -1, 0, 0, 0, 8);
        for (int k = 0; k < 4; k++) chk($sformatf("lw_addr%0d", k), a_tr[k+1], 32'h1000 + k);
        chk("lw_fin_rel", fin_rel, 6);
        chk("lw_val", fin_val, 32'h12345678);
        chk("lw_fin_cnt", fin_cnt, 1);
        chk("lw_no_wr", wr_cnt, 0);

        // LB / LBU / LH / LHU
        run(LS_LB, 32'h20, 0, -1, 0, 0, 0, 5);
        chk("lb_fin_rel", fin_rel, 3);
        chk("lb_val", fin_val, 32'hFFFFFF80);
        run(LS_LBU, 32'h20, 0, -1, 0, 0, 0, 5);
        chk("lbu_fin_rel", fin_rel, 3);
        chk("lbu_val", fin_val, 32'h00000080);
        run(LS_LH, 32'h40, 0, -1, 0, 0, 0, 6);
        chk("lh_fin_rel", fin_rel, 4);
        chk("lh_val", fin_val, 32'hFFFF8FF0);
        run(LS_LHU, 32'h40, 0, -1, 0, 0, 0, 6);
        chk("lhu_val", fin_val, 32'h00008FF0);

        // SH across 0x1FFF/0x2000
        run(LS_SH, 32'h1FFF, 32'hABCD1234, -1, 0, 0, 0, 6);
        chk("sh_wr_cnt", wr_cnt, 2);
        chk("sh_a0", wr_a[0], 32'h1FFF);
        chk("sh_d0", {24'd0, wr_d[0]}, 32'h34);
        chk("sh_r0", wr_rel[0], 1);
        chk("sh_a1", wr_a[1], 32'h2000);
        chk("sh_d1", {24'd0, wr_d[1]}, 32'h12);
        chk("sh_r1", wr_rel[1], 2);
        chk("sh_fin_rel", fin_rel, 3);
        chk("sh_fin_val", fin_val, 32'd0);

        // LW aborted by clear in T+2; an LB must be accepted in T+3
        run(LS_LW, 32'h1000, 0, 2, 0, 0, 0, 2);
        chk("lwclr_fin_cnt", fin_cnt, 0);
        run(LS_LB, 32'h20, 0, -1, 0, 0, 0, 8);
        chk("after_clr_fin_rel", fin_rel, 3);
        chk("after_clr_val", fin_val, 32'hFFFFFF80);
        chk("after_clr_fin_cnt", fin_cnt, 1);

        // SW with clear in T+2: all bytes written, no pulse
        run(LS_SW, 32'h3000, 32'hCAFEF00D, 2, 0, 0, 0, 8);
        chk("swclr_wr_cnt", wr_cnt, 4);
        chk("swclr_a3", wr_a[3], 32'h3003);
        chk("swclr_d3", {24'd0, wr_d[3]}, 32'hCA);
        chk("swclr_r3", wr_rel[3], 4);
        chk("swclr_fin_cnt", fin_cnt, 0);

        // SB to IO space with buffer full for 5 cycles
        run(LS_SB, 32'h30000, 32'h41, -1, 0, 0, 5, 10);
        chk("io_wr_cnt", wr_cnt, 1);
        chk("io_a", wr_a[0], 32'h30000);
        chk("io_d", {24'd0, wr_d[0]}, 32'h41);
`ifdef MEMCTRL_IO_STALL_EN
        chk("io_wr_rel", wr_rel[0], 6);
        chk("io_fin_rel", fin_rel, 7);
`else
        chk("io_wr_rel", wr_rel[0], 1);
        chk("io_fin_rel", fin_rel, 2);
`endif

        // rdy_in low for T+3..T+5 mid-LW
        run(LS_LW, 32'h1000, 0, -1, 3, 3, 0, 12);
        chk("rdy_fin_rel", fin_rel, 9);
        chk("rdy_val", fin_val, 32'h12345678);
        chk("rdy_fin_cnt", fin_cnt, 1);

        // reset in the middle of a SW abandons it
        run(LS_SW, 32'h100, 32'hDEADBEEF, -1, 0, 0, 0, 2);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        idle_wr = 0; idle_fin = 0;
        for (int r = 0; r < 6; r++) begin
            @(negedge clk_in);
            if (mem_wr) idle_wr++;
            if (ls_finished) idle_fin++;
        end
        chk("rstmid_wr", idle_wr, 0);
        chk("rstmid_fin", idle_fin, 0);
        chk("rstmid_last_byte", {31'd0, ram.exists(32'h103)}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
